fcp_txq: RTL and testbench

FCP_TXQ -- requirements
Module: fcp_txq

---
 rtl/fcp_txq.sv | 228 ++++++++++++++++++++++
 tb/tb_fcp_txq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fcp_txq.sv
// Byte FIFO feeding a framed serial transmitter: SYNC, data bytes, optional CRC-8 byte, END.
// Define FCP_TXQ_CRC_EN to build the CRC state and the running r_crc; otherwise r_crc reads 8'h00.
module fcp_txq #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned UI_CYC   = 16,
  parameter logic [7:0]  CRC_POLY = 8'h07,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned UW      = $clog2(UI_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    r_wdat,
  input  logic          r_push,
  input  logic          r_start,
  input  logic          r_abort,
  input  logic          r_clr,
  output logic          tx_en,
  output logic          tx_dat,
  output logic          busy,
  output logic          intr,
  output logic          ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   r_lvl,
  output logic [7:0]    r_crc
);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_BYTE, ST_CRC, ST_END} state_t;

  state_t          state_q, state_d;
  logic [UW-1:0]   ui_q, ui_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            tx_en_q, tx_dat_q, busy_q, intr_q, ovf_q;
  logic            tx_dat_d, intr_d, ovf_d;
  logic            pop, push_ok, crc_clr, ui_done;
  logic [7:0]      mem [DEPTH];
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [7:0]      head;

  assign r_lvl   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (r_lvl == (AW+1)'(DEPTH));
  assign head    = mem[rd_q[AW-1:0]];
  assign ui_done = (ui_q == UW'(UI_CYC - 1));

`ifdef FCP_TXQ_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[7] ^ d[3'(7 - i)];
      c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
    return c;
  endfunction

  // byte_q holds the byte popped in the first BYTE cycle, so it is the CRC input here
  always_comb begin
    crc_d = crc_q;
    if (crc_clr)  crc_d = '0;
    else if (pop) crc_d = crc8_step(crc_q, byte_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign r_crc = crc_q;
`else
  assign r_crc = '0;
`endif

  always_comb begin
    state_d = state_q;
    ui_d    = ui_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    crc_clr = 1'b0;
    intr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ui_d  = '0;
        bit_d = '0;
        if (r_start && !empty) begin
          state_d = ST_SYNC;
          crc_clr = 1'b1;
        end
      end
      ST_SYNC: begin
        if (ui_done) begin
          ui_d = '0;
          if (bit_q == 4'd1) begin
            state_d = ST_BYTE;
            bit_d   = '0;
            byte_d  = head;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_BYTE: begin
        if (ui_q == '0 && bit_q == '0) pop = !empty;
        if (ui_done) begin
          ui_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = '0;
            if (!empty) begin
              byte_d = head;
            end else begin
`ifdef FCP_TXQ_CRC_EN
              state_d = ST_CRC;
              byte_d  = crc_q;
`else
              state_d = ST_END;
`endif
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef FCP_TXQ_CRC_EN
      ST_CRC: begin
        if (ui_done) begin
          ui_d = '0;
          if (bit_q == 4'd9) begin
            state_d = ST_END;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`endif
      ST_END: begin
        if (ui_done) begin
          state_d = ST_IDLE;
          ui_d    = '0;
          bit_d   = '0;
          intr_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ui_d    = '0;
        bit_d   = '0;
      end
    endcase
    if (r_abort) begin
      state_d = ST_IDLE;
      ui_d    = '0;
      bit_d   = '0;
      pop     = 1'b0;
      crc_clr = 1'b0;
      intr_d  = 1'b0;
    end
  end

  // Line outputs are registered from next-state values so they change on the state edge
  always_comb begin
    tx_dat_d = 1'b1;
    if (state_d == ST_SYNC) begin
      tx_dat_d = 1'b0;
    end else if (state_d == ST_BYTE || state_d == ST_CRC) begin
      if (bit_d < 4'd8)       tx_dat_d = byte_d[3'd7 - bit_d[2:0]];
      else if (bit_d == 4'd8) tx_dat_d = ~^byte_d;
    end
  end

  assign push_ok = r_push && !r_abort && (!full || pop);

  always_comb begin
    wr_d  = wr_q + (AW+1)'(push_ok);
    rd_d  = rd_q + (AW+1)'(pop);
    ovf_d = ovf_q;
    if (r_clr) ovf_d = 1'b0;
    if (r_push && !r_abort && full && !pop) ovf_d = 1'b1;
    if (r_abort) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= r_wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ui_q     <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tx_en_q  <= 1'b0;
      tx_dat_q <= 1'b1;
      busy_q   <= 1'b0;
      intr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ui_q     <= ui_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tx_en_q  <= (state_d != ST_IDLE);
      tx_dat_q <= tx_dat_d;
      busy_q   <= (state_d != ST_IDLE);
      intr_q   <= intr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_en  = tx_en_q;
  assign tx_dat = tx_dat_q;
  assign busy   = busy_q;
  assign intr   = intr_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_fcp_txq.sv
// Directed bench for fcp_txq with DEPTH=4, UI_CYC=16; expectations follow FCP_TXQ_CRC_EN if defined.
module tb_fcp_txq;

`ifdef FCP_TXQ_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_wdat = '0;
  logic       r_push = 1'b0, r_start = 1'b0, r_abort = 1'b0, r_clr = 1'b0;
  logic       tx_en, tx_dat, busy, intr, ovf, full, empty;
  logic [2:0] r_lvl;
  logic [7:0] r_crc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fcp_txq #(.DEPTH(4), .UI_CYC(16), .CRC_POLY(8'h07)) dut (
    .clk(clk), .rst(rst), .r_wdat(r_wdat), .r_push(r_push), .r_start(r_start),
    .r_abort(r_abort), .r_clr(r_clr), .tx_en(tx_en), .tx_dat(tx_dat), .busy(busy),
    .intr(intr), .ovf(ovf), .full(full), .empty(empty), .r_lvl(r_lvl), .r_crc(r_crc)
  );

  typedef struct {
    logic       push;
    logic [7:0] wdat;
    logic       start, abort, clr;
    logic       full, empty;
    logic [2:0] lvl;
    logic       ovf, busy;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC of a single byte from init 0: long division of {d,8'h00} by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] v;
    v = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (v[i]) v = v ^ (16'h0107 << (i - 8));
    return v[7:0];
  endfunction

  function automatic logic frame_bit(input logic [7:0] x, input int k);
    if (k < 8)  return x[7 - k];
    if (k == 8) return ~^x;
    return 1'b1;
  endfunction

  function automatic logic ui_bit(input logic [7:0] b, input logic [7:0] c, input int u);
    if (u < 2)  return 1'b0;
    if (u < 12) return frame_bit(b, u - 2);
    if (CRC_ON && u < 22) return frame_bit(c, u - 12);
    return 1'b1;
  endfunction

  // One-byte frame, FIFO must hold exactly b before the call
  task automatic run_frame(input logic [7:0] b);
    logic [7:0] c;
    int         nui;
    c   = ref_crc(b);
    nui = CRC_ON ? 23 : 13;
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    for (int u = 0; u < nui; u++)
      for (int k = 0; k < 16; k++) begin
        check($sformatf("frame%02h_ui%0d", b, u), {28'd0, tx_en, busy, intr, tx_dat},
              {28'd0, 1'b1, 1'b1, 1'b0, ui_bit(b, c, u)});
        tick();
      end
    check("frame_end_line", {29'd0, tx_en, busy, tx_dat}, {29'd0, 1'b0, 1'b0, 1'b1});
    check("frame_end_intr", {31'd0, intr}, 32'd1);
    check("frame_crc", {24'd0, r_crc}, {24'd0, CRC_ON ? c : 8'h00});
    tick();
    check("intr_one_cycle", {31'd0, intr}, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    r_wdat = d;
    r_push = 1'b1;
    tick();
    r_push = 1'b0;
  endtask

  initial begin
    int intr_seen;
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};

    repeat (3) tick();
    check("rst_line", {30'd0, tx_en, tx_dat}, {30'd0, 1'b0, 1'b1});
    check("rst_flags", {28'd0, busy, intr, ovf, full}, 32'd0);
    check("rst_fifo", {28'd0, empty, r_lvl}, {28'd0, 1'b1, 3'd0});
    check("rst_crc", {24'd0, r_crc}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int unsigned i = 0; i < 11; i++) begin
      r_push = vecs[i].push; r_wdat = vecs[i].wdat; r_start = vecs[i].start;
      r_abort = vecs[i].abort; r_clr = vecs[i].clr;
      tick();
      r_push = 1'b0; r_start = 1'b0; r_abort = 1'b0; r_clr = 1'b0;
      check($sformatf("vec%0d_fifo", i), {27'd0, full, empty, r_lvl},
            {27'd0, vecs[i].full, vecs[i].empty, vecs[i].lvl});
      check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("vec%0d_busy", i), {30'd0, busy, tx_en}, {30'd0, vecs[i].busy, vecs[i].busy});
    end

    run_frame(8'h01);
    push_byte(8'hA5);
    run_frame(8'hA5);

    // Full FIFO: push in the BYTE pop cycle is accepted without overflow
    push_byte(8'h10); push_byte(8'h20); push_byte(8'h30); push_byte(8'h40);
    check("full_before_start", {31'd0, full}, 32'd1);
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    repeat (32) tick();
    check("byte_first_cycle_lvl", {29'd0, r_lvl}, 32'd4);
    r_wdat = 8'h50; r_push = 1'b1;
    tick();
    r_push = 1'b0;
    check("push_pop_full_lvl", {29'd0, r_lvl}, 32'd4);
    check("push_pop_full_ovf", {31'd0, ovf}, 32'd0);
    // Third UI of byte 1 (0x10): bit index 2 is data bit 5 = 0
    repeat (35) tick();
    check("ui3_line", {29'd0, busy, tx_en, tx_dat}, {29'd0, 1'b1, 1'b1, 1'b0});
    r_abort = 1'b1; r_start = 1'b1;
    tick();
    r_abort = 1'b0; r_start = 1'b0;
    check("abort_line", {29'd0, busy, tx_en, tx_dat}, {29'd0, 1'b0, 1'b0, 1'b1});
    check("abort_fifo", {28'd0, empty, r_lvl}, {28'd0, 1'b1, 3'd0});
    check("abort_crc_kept", {24'd0, r_crc}, {24'd0, CRC_ON ? ref_crc(8'h10) : 8'h00});
    intr_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (intr || busy) intr_seen++;
      tick();
    end
    check("abort_no_intr", intr_seen, 0);

    // Mid-frame asynchronous reset
    push_byte(8'h55);
    push_byte(8'h66);
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    repeat (50) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_line", {29'd0, tx_en, tx_dat, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    check("async_rst_fifo", {27'd0, empty, full, r_lvl}, {27'd0, 1'b1, 1'b0, 3'd0});
    check("async_rst_flags", {22'd0, intr, ovf, r_crc}, 32'd0);
    @(negedge clk) rst = 1'b0;
    intr_seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (intr || busy || tx_en) intr_seen++;
    end
    check("post_rst_quiet", intr_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
